// File: rtl/fchan_pkg.sv
// Shared definitions for the channel-subset capture and unpack stages.
// Latency: n/a (types, constants and a combinational search function).
// Backpressure: n/a.
package fchan_pkg;

  // Defaults shared with the capture side
  localparam int FCHAN_DW      = 20;
  localparam int FCHAN_LEN     = 16;
  localparam int FCHAN_AW      = 10;
  localparam int FCHAN_CW      = 4;
  // Widest mask the search function handles; masks are zero-extended to this
  localparam int FCHAN_MAX_LEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fchan_state_t;

  // Result of one tag advance: next channel index and whether it wrapped
  typedef struct packed {
    logic       wrap;
    logic [7:0] idx;
  } tag_step_t;

  // Next set bit above cur in a channel-ordered mask (bit c = channel c),
  // wrapping to the lowest set bit. Passing cur = 8'hFF yields the lowest
  // set bit, which is how the first tag of a readout is found.
  function automatic tag_step_t next_set(input logic [FCHAN_MAX_LEN-1:0] mask,
                                         input logic [7:0]               cur,
                                         input int                       n);
    tag_step_t r;
    r.wrap = 1'b1;
    r.idx  = 8'd0;
    for (int c = FCHAN_MAX_LEN - 1; c >= 0; c--) begin
      if (c < n && mask[c]) r.idx = 8'(c);
    end
    for (int c = FCHAN_MAX_LEN - 1; c >= 0; c--) begin
      if (c < n && mask[c] && 8'(c) > cur) begin
        r.idx  = 8'(c);
        r.wrap = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fchan_skid.sv
// Two-entry skid buffer between memory read data and the sample output.
// Latency: 0 when empty (input bypasses to output), otherwise FIFO order.
// Backpressure: input cannot stall; caller throttles using free (slots after this cycle).
module fchan_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   free
);

  logic [1:0]   occ;
  logic [1:0]   occ_next;
  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         pop_buf;
  logic         push_buf;

  // Output mux, push/pop decisions and the occupancy the next cycle will see
  always_comb begin
    out_vld  = (occ != 2'd0) | in_vld;
    out_dat  = '0;
    if (occ != 2'd0) out_dat = e0;
    else if (in_vld) out_dat = in_dat;
    pop_buf  = (occ != 2'd0) && out_rdy;
    // An arriving word is stored unless it goes straight out through the bypass
    push_buf = in_vld && !(occ == 2'd0 && out_rdy);
    occ_next = occ;
    if (push_buf && !pop_buf) occ_next = occ + 2'd1;
    if (!push_buf && pop_buf) occ_next = occ - 2'd1;
    free     = 2'd2 - occ_next;
  end

  // Storage: e0 is the head, e1 the second entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      occ <= occ_next;
      if (pop_buf && push_buf) begin
        if (occ == 2'd1) begin
          e0 <= in_dat;
        end else begin
          e0 <= e1;
          e1 <= in_dat;
        end
      end else if (pop_buf) begin
        e0 <= e1;
      end else if (push_buf) begin
        if (occ == 2'd0) e0 <= in_dat;
        else             e1 <= in_dat;
      end
    end
  end

endmodule

// File: rtl/fchan_unpack.sv
// Walks waveform memory after capture and re-tags each sample with its channel index (FCHAN_UNPACK_BLKCNT_EN adds o_blk).
// Latency: start -> mem_rd next cycle -> o_valid one cycle later; 1 word/cycle with o_ready high.
// Backpressure: o_ready stalls output; reads throttled so in-flight + buffered never exceeds 2.
module fchan_unpack
  import fchan_pkg::*;
#(
  parameter int dw  = FCHAN_DW,
  parameter int len = FCHAN_LEN,
  parameter int aw  = FCHAN_AW,
  parameter int cw  = FCHAN_CW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [len-1:0] keep,
  input  logic [aw:0]    count,
  input  logic           start,
  output logic           busy,
  output logic           err,
  output logic [aw-1:0]  mem_addr,
  output logic           mem_rd,
  input  logic [dw-1:0]  mem_data,
  output logic [dw-1:0]  o_data,
  output logic [cw-1:0]  o_chan,
  output logic           o_last,
  output logic           o_valid,
  input  logic           o_ready
`ifdef FCHAN_UNPACK_BLKCNT_EN
  ,
  output logic [aw-1:0]  o_blk
`endif
);

  localparam logic [aw:0] ONE = (aw + 1)'(1);
`ifdef FCHAN_UNPACK_BLKCNT_EN
  localparam int SW = dw + cw + 1 + aw;
`else
  localparam int SW = dw + cw + 1;
`endif

  fchan_state_t             state;
  logic [FCHAN_MAX_LEN-1:0] keep_c;
  logic [FCHAN_MAX_LEN-1:0] kmask_q;
  logic [aw:0]              cnt_q;
  logic [aw:0]              rd_idx;
  logic [cw-1:0]            cur_chan;
  logic [cw-1:0]            rd_chan;
  logic                     rd_last;
  logic                     in_vld;
  logic [cw-1:0]            in_chan;
  logic                     in_last;
  tag_step_t                step_first;
  tag_step_t                step_second;
  tag_step_t                step_run;
  logic [1:0]               free;
  logic                     can_issue;
  logic [SW-1:0]            skid_in;
  logic [SW-1:0]            skid_out;
`ifdef FCHAN_UNPACK_BLKCNT_EN
  logic [aw-1:0]            blk_cnt;
  logic [aw-1:0]            rd_blk;
  logic [aw-1:0]            in_blk;
`endif

  // Reorder the mask so bit c is channel c (capture is MSB-first), then run the tag searches
  always_comb begin
    keep_c = '0;
    for (int c = 0; c < len; c++) keep_c[c] = keep[len-1-c];
    step_first  = next_set(keep_c, 8'hFF, len);
    step_second = next_set(keep_c, step_first.idx, len);
    step_run    = next_set(kmask_q, 8'(cur_chan), len);
    // Room must exist for this read plus the one already on the memory bus
    can_issue   = free > {1'b0, mem_rd};
  end

  // Readout FSM: issues reads, carries each read's tag, tracks busy/err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      err      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      kmask_q  <= '0;
      cnt_q    <= '0;
      rd_idx   <= '0;
      cur_chan <= '0;
      rd_chan  <= '0;
      rd_last  <= 1'b0;
`ifdef FCHAN_UNPACK_BLKCNT_EN
      blk_cnt  <= '0;
      rd_blk   <= '0;
`endif
    end else begin
      mem_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (keep == '0) begin
              err <= 1'b1;
            end else if (count != '0) begin
              // First read goes out immediately so mem_rd appears the next cycle
              err      <= 1'b0;
              busy     <= 1'b1;
              kmask_q  <= keep_c;
              cnt_q    <= count;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              rd_chan  <= cw'(step_first.idx);
              rd_last  <= (count == ONE);
              cur_chan <= cw'(step_second.idx);
              rd_idx   <= ONE;
`ifdef FCHAN_UNPACK_BLKCNT_EN
              rd_blk   <= '0;
              blk_cnt  <= step_second.wrap ? aw'(1) : '0;
`endif
              state    <= (count == ONE) ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (can_issue) begin
            mem_rd   <= 1'b1;
            mem_addr <= rd_idx[aw-1:0];
            rd_chan  <= cur_chan;
            rd_last  <= (rd_idx == cnt_q - ONE);
            cur_chan <= cw'(step_run.idx);
            rd_idx   <= rd_idx + ONE;
`ifdef FCHAN_UNPACK_BLKCNT_EN
            rd_blk   <= blk_cnt;
            if (step_run.wrap) blk_cnt <= blk_cnt + aw'(1);
`endif
            if (rd_idx == cnt_q - ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (o_valid && o_ready && o_last) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay the tag one cycle so it lines up with the returning memory word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld  <= 1'b0;
      in_chan <= '0;
      in_last <= 1'b0;
`ifdef FCHAN_UNPACK_BLKCNT_EN
      in_blk  <= '0;
`endif
    end else begin
      in_vld  <= mem_rd;
      in_chan <= rd_chan;
      in_last <= rd_last;
`ifdef FCHAN_UNPACK_BLKCNT_EN
      in_blk  <= rd_blk;
`endif
    end
  end

`ifdef FCHAN_UNPACK_BLKCNT_EN
  assign skid_in = {mem_data, in_chan, in_last, in_blk};
  assign {o_data, o_chan, o_last, o_blk} = skid_out;
`else
  assign skid_in = {mem_data, in_chan, in_last};
  assign {o_data, o_chan, o_last} = skid_out;
`endif

  fchan_skid #(
    .W(SW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_dat  (skid_in),
    .out_vld (o_valid),
    .out_rdy (o_ready),
    .out_dat (skid_out),
    .free    (free)
  );

endmodule

// File: tb/tb_fchan_unpack.sv
// Directed bench for fchan_unpack: streams, tagging, err, backpressure, reset abort.
// Memory model returns its address one cycle after mem_rd.
// Outputs sampled 2 time units after the rising edge; inputs driven 1 unit after.
module tb_fchan_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keep = '0;
  logic [10:0] count = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        err;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [19:0] mem_data = '0;
  logic [19:0] o_data;
  logic [3:0]  o_chan;
  logic        o_last;
  logic        o_valid;
  logic        o_ready = 1'b0;
`ifdef FCHAN_UNPACK_BLKCNT_EN
  logic [9:0]  o_blk;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int got_tags[$];
  int got_blks[$];

  fchan_unpack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .keep     (keep),
    .count    (count),
    .start    (start),
    .busy     (busy),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .o_data   (o_data),
    .o_chan   (o_chan),
    .o_last   (o_last),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
`ifdef FCHAN_UNPACK_BLKCNT_EN
    ,
    .o_blk    (o_blk)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= 20'(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One readout: start, collect n words, check data/tags/last/latency/hold/throttle
  task automatic run_stream(input logic [15:0] k, input int n, input int rdy_pct,
                            input int abort_at, input bit poke);
    int tags[$];
    int idx, cyc, issued, outstanding, max_out, addr_bad, stall_bad, guard;
    bit held, poked, aborted;
    logic [19:0] hd;
    logic [3:0]  hc;
    logic        hl;
    tags = {};
    for (int c = 0; c < 16; c++) if (k[15-c]) tags.push_back(c);
    got_tags.delete();
    got_blks.delete();
    idx = 0; cyc = 0; issued = 0; max_out = 0; addr_bad = 0; stall_bad = 0; guard = 0;
    held = 0; poked = 0; aborted = 0; hd = '0; hc = '0; hl = 1'b0;
    keep  = k;
    count = 11'(n);
    start = 1'b1;
    while (idx < n && guard < 20 * n + 50) begin
      tick();
      cyc++;
      guard++;
      start = 1'b0;
      if (poke && !poked && idx == 5) begin
        start = 1'b1;
        keep  = 16'h0001;
        count = 11'd7;
        poked = 1;
      end
      o_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (cyc == 1) begin
        chk("start_busy", busy, 1);
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, 0);
      end
      if (mem_rd) begin
        if (mem_addr != 10'(issued)) addr_bad++;
        issued++;
      end
      outstanding = issued - idx;
      if (outstanding > max_out) max_out = outstanding;
      if (held && (!o_valid || o_data !== hd || o_chan !== hc || o_last !== hl)) stall_bad++;
      if (o_valid && o_ready) begin
        chk("data", o_data, 32'(idx));
        chk("chan", o_chan, 32'(tags[idx % tags.size()]));
        chk("last", o_last, 32'(idx == n - 1));
`ifdef FCHAN_UNPACK_BLKCNT_EN
        chk("blk", o_blk, 32'(idx / tags.size()));
        got_blks.push_back(int'(o_blk));
`endif
        if (rdy_pct == 100 && idx == 0) chk("lat_first", cyc, 2);
        if (rdy_pct == 100 && idx == n - 1) chk("lat_last", cyc, 32'(n + 1));
        got_tags.push_back(int'(o_chan));
        idx++;
        held = 0;
      end else begin
        held = o_valid;
        hd = o_data; hc = o_chan; hl = o_last;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd", mem_rd, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_data", o_data, 0);
        chk("abort_chan", o_chan, 0);
        chk("abort_last", o_last, 0);
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      tick();
      rst_n = 1'b1;
    end else begin
      chk("stream_done", idx, 32'(n));
      tick();
      chk("busy_fall", busy, 0);
      chk("err_after_valid_start", err, 0);
      chk("reads_issued", issued, 32'(n));
      chk("rd_addr_order", addr_bad, 0);
      chk("max_outstanding_le2", 32'(max_out <= 2), 1);
      chk("stall_hold", stall_bad, 0);
    end
    keep  = '0;
    count = '0;
  endtask

  // Start that must not launch a readout; returns after a few idle cycles
  task automatic idle_start(input logic [15:0] k, input int n, input logic exp_err);
    int rd_seen, busy_seen, vld_seen;
    rd_seen = 0; busy_seen = 0; vld_seen = 0;
    keep = k;
    count = 11'(n);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      #1;
      if (mem_rd) rd_seen++;
      if (busy) busy_seen++;
      if (o_valid) vld_seen++;
    end
    chk("idle_err", err, 32'(exp_err));
    chk("idle_no_busy", busy_seen, 0);
    chk("idle_no_rd", rd_seen, 0);
    chk("idle_no_valid", vld_seen, 0);
  endtask

  initial begin
    int exp_a000[6];
    exp_a000 = '{0, 2, 0, 2, 0, 2};
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_chan", o_chan, 0);
    rst_n = 1'b1;
    tick();

    // Full mask, full rate: chan 0..15 twice, data 0..31, busy low at cycle 34
    run_stream(16'hFFFF, 32, 100, -1, 0);

    // Sparse mask: only keep[15] and keep[13] -> tags 0,2,0,2,...
    run_stream(16'hA000, 6, 100, -1, 0);
    for (int i = 0; i < 6; i++) chk("a000_tag", got_tags[i], exp_a000[i]);
`ifdef FCHAN_UNPACK_BLKCNT_EN
    for (int i = 0; i < 6; i++) chk("a000_blk", got_blks[i], i / 2);
`endif

    // Empty mask flags err; a following valid start clears it
    idle_start(16'h0000, 5, 1'b1);
    run_stream(16'h0100, 1, 100, -1, 0);
    chk("single_tag", got_tags[0], 7);

    // 50% backpressure, 100 words, mask 0x1234 -> channels 3,6,10,11,13
    run_stream(16'h1234, 100, 50, -1, 0);

    // Reset mid-readout at word 40, then restart from address 0
    run_stream(16'hFFFF, 100, 100, 40, 0);
    run_stream(16'h0F0F, 10, 100, -1, 0);

    // Start plus keep/count changes while busy are ignored
    run_stream(16'h8001, 20, 70, -1, 1);

    // count == 0: nothing happens
    idle_start(16'hFFFF, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
